axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Shares one AXI4 master read port (AR + R channels) among NUM_REQ internal requesters.
- Grants in round-robin order with one burst outstanding at a time.
- Drives the AR channel, then steers R beats back to the granted requester.
- Sits between the cache/DMA request ports and the AXI master interface driven by the UVM master agent.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
NUM_ID, 4, ARID/RID width; must be >= clog2(NUM_REQ)
DATA_LEN, 32, RDATA width in bits (32 or 64)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester read request
req_ready  out  NUM_REQ  request accepted (one-hot, single-cycle)
req_addr  in  NUM_REQ*32  packed start addresses, requester i at [32*i+:32]
req_len  in  NUM_REQ*8  packed AXI lengths (beats-1)
rsp_valid  out  NUM_REQ  read beat valid to requester (one-hot)
rsp_ready  in  NUM_REQ  requester accepts beat
rsp_data  out  DATA_LEN  shared beat data
rsp_last  out  1  last beat of burst
rsp_resp  out  2  RRESP of the beat
ARVALID  out  1  AXI address valid
ARREADY  in  1  AXI address ready
ARADDR  out  32  burst address
ARLEN  out  8  burst length
ARSIZE  out  3  clog2(DATA_LEN/8), constant
ARBURST  out  2  2'b01 (INCR), constant
ARID  out  NUM_ID  granted requester index, zero-extended
RVALID  in  1  AXI read data valid
RREADY  out  1  AXI read data ready
RDATA  in  DATA_LEN  read data
RRESP  in  2  read response
RID  in  NUM_ID  read ID
RLAST  in  1  last beat
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- One clock, ACLK. Reset is asynchronous and active-low on ARESETn.
- Reset values: state=IDLE, ARVALID=0, ARADDR=0, ARLEN=0, ARID=0, req_ready=0, err=0, last_grant=NUM_REQ-1.
- Reset also forces RREADY, rsp_valid, rsp_last and rsp_resp to 0, because they are gated by state. Requester 0 therefore wins first.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid is set, grant g = first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Same cycle: req_ready[g]=1 (registered, visible the next cycle; the requester must hold req_valid/addr/len until it sees req_ready).
  - Latch ARADDR=req_addr[g], ARLEN=req_len[g], ARID=g, and go to ADDR.
  - Implementation: register the grant in IDLE, pulse req_ready on the IDLE->ADDR transition cycle. req_ready is high for exactly one cycle per grant.
- ADDR:
  - ARVALID=1. ARADDR, ARLEN and ARID are held stable until ARVALID&ARREADY.
  - On the handshake: ARVALID=0 next cycle, clear beat counter, go to DATA.
- DATA: combinational pass-through, zero added latency.
  - RREADY = rsp_ready[g].
  - rsp_valid[g] = RVALID; all other rsp_valid bits are 0.
  - rsp_data = RDATA, rsp_last = RLAST, rsp_resp = RRESP.
  - On RVALID&RREADY: beat counter +1 (9-bit, so ARLEN=255 cannot overflow).
  - On RVALID&RREADY&RLAST: last_grant=g, go to IDLE.
  - A new grant cannot occur in the same cycle as the last beat; minimum one IDLE cycle between bursts.
- Outside DATA: RREADY=0 and rsp_valid=0; stray R beats are not accepted.
- Simultaneous requests: strict round-robin. A requester that was just served has lowest priority next time.
- Single requester continuously valid: served back-to-back, with 1 IDLE cycle between bursts.
- Reset mid-operation: returns to IDLE immediately. The outstanding burst is abandoned; no rsp_valid is issued after reset deassertion.

Optional Feature:
- Macro: AXI_RD_ARB_CHECK_EN.
- Defined: err is set (sticky until reset) on any accepted R beat where any of the following holds:
  - RID != latched ARID;
  - RLAST=1 with beat count != ARLEN;
  - RLAST=0 with beat count == ARLEN.
- Defined: the burst still terminates on RLAST only.
- Not defined: err is tied to 0 and no checker logic is built.

Test Plan:
- Single request: req_valid=01, addr=0x1000, len=3 -> req_ready[0] pulses once; ARADDR=0x1000, ARLEN=3, ARID=0, ARSIZE=2, ARBURST=01; 4 beats on rsp_valid[0], rsp_last on beat 4; FSM back to IDLE.
- Round-robin: both requesters held valid for 4 bursts (len=0) -> grant order 0,1,0,1; ARID sequence 0,1,0,1.
- AR backpressure: ARREADY low for 5 cycles -> ARVALID stays 1 and ARADDR/ARLEN/ARID are stable; handshake on cycle 6; no R accepted before it.
- R backpressure: rsp_ready[1] toggles 1,0,1,0 on a len=3 burst -> RREADY mirrors it; exactly 4 accepted beats with data in order; rsp_valid[0] stays 0 throughout.
- Reset mid-burst: ARESETn low during beat 2 of 4 -> all outputs at reset values asynchronously; after release, requester 0 is granted first and no stale rsp_valid appears.
- Checker (AXI_RD_ARB_CHECK_EN defined): RLAST on beat 2 of len=3, or RID=1 while ARID=0 -> err=1 and stays 1. Without the macro, same stimulus -> err=0.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// Bus bundles for axi_rd_arbiter: the requester-side port (rd_req_if) and
// the AXI4 read master port (axi_rd_if). The arbiter is slave on rd_req_if and master on axi_rd_if.
interface rd_req_if #(
  parameter int NUM_REQ  = 2,
  parameter int DATA_LEN = 32
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*8-1:0]  req_len;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [DATA_LEN-1:0]   rsp_data;
  logic                  rsp_last;
  logic [1:0]            rsp_resp;

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_resp
  );
  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_resp
  );
endinterface

interface axi_rd_if #(
  parameter int NUM_ID   = 4,
  parameter int DATA_LEN = 32
);
  logic                ARVALID;
  logic                ARREADY;
  logic [31:0]         ARADDR;
  logic [7:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic [NUM_ID-1:0]   ARID;
  logic                RVALID;
  logic                RREADY;
  logic [DATA_LEN-1:0] RDATA;
  logic [1:0]          RRESP;
  logic [NUM_ID-1:0]   RID;
  logic                RLAST;

  modport master (
    output ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP, RID, RLAST
  );
  modport slave (
    input  ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID, RREADY,
    output ARREADY, RVALID, RDATA, RRESP, RID, RLAST
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_REQ requesters, one burst in flight.
// Define AXI_RD_ARB_CHECK_EN to build the sticky R-channel protocol checker driving err.
module axi_rd_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int NUM_ID   = 4,
  parameter int DATA_LEN = 32
) (
  input  logic      ACLK,
  input  logic      ARESETn,
  rd_req_if.slave   req,
  axi_rd_if.master  axi,
  output logic      err
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [GW-1:0]        grant_r, last_grant_r, pick_s, idx_s;
  logic                 pick_vld_s, grant_now_s, ar_hs_s, in_data_s, rd_beat_s;
  logic [NUM_REQ-1:0]   req_ready_r;
  logic                 arvalid_r;
  logic [31:0]          araddr_r, addr_s;
  logic [7:0]           arlen_r, len_s;
  logic [8:0]           beat_r;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
    onehot      = {NUM_REQ{1'b0}};
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin pick: first valid requester after last_grant, wrapping; smallest offset wins
  always_comb begin
    pick_s     = last_grant_r;
    pick_vld_s = 1'b0;
    idx_s      = {GW{1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx_s      = GW'((int'(last_grant_r) + k) % NUM_REQ);
      pick_vld_s = pick_vld_s | req.req_valid[idx_s];
      pick_s     = req.req_valid[idx_s] ? idx_s : pick_s;
    end
  end

  // Select address and length of the picked requester
  always_comb begin
    addr_s = 32'h0000_0000;
    len_s  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_s = (pick_s == GW'(i)) ? req.req_addr[32*i +: 32] : addr_s;
      len_s  = (pick_s == GW'(i)) ? req.req_len[8*i +: 8]   : len_s;
    end
  end

  assign grant_now_s = (state_r == IDLE) && pick_vld_s;
  assign ar_hs_s     = arvalid_r && axi.ARREADY;
  assign in_data_s   = (state_r == DATA);
  assign rd_beat_s   = in_data_s && axi.RVALID && axi.RREADY;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = pick_vld_s ? ADDR : IDLE;
      ADDR:    state_s = ar_hs_s ? DATA : ADDR;
      DATA:    state_s = (rd_beat_s && axi.RLAST) ? IDLE : DATA;
      default: state_s = IDLE;
    endcase
  end

  // State, grant, latched AR fields and beat counter
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r      <= IDLE;
      arvalid_r    <= 1'b0;
      araddr_r     <= 32'h0000_0000;
      arlen_r      <= 8'h00;
      grant_r      <= {GW{1'b0}};
      last_grant_r <= GW'(NUM_REQ - 1);
      req_ready_r  <= {NUM_REQ{1'b0}};
      beat_r       <= 9'd0;
    end else begin
      state_r     <= state_s;
      arvalid_r   <= (state_s == ADDR);
      req_ready_r <= grant_now_s ? onehot(pick_s) : {NUM_REQ{1'b0}};
      if (grant_now_s) begin
        grant_r  <= pick_s;
        araddr_r <= addr_s;
        arlen_r  <= len_s;
      end
      if (ar_hs_s) begin
        beat_r <= 9'd0;
      end else if (rd_beat_s) begin
        beat_r <= beat_r + 9'd1;
      end
      if (rd_beat_s && axi.RLAST) begin
        last_grant_r <= grant_r;
      end
    end
  end

  assign req.req_ready = req_ready_r;
  assign axi.ARVALID   = arvalid_r;
  assign axi.ARADDR    = araddr_r;
  assign axi.ARLEN     = arlen_r;
  assign axi.ARID      = NUM_ID'(grant_r);
  assign axi.ARSIZE    = 3'($clog2(DATA_LEN / 8));
  assign axi.ARBURST   = 2'b01;

  // R channel is a zero-latency pass-through, gated off outside DATA so stray beats are dropped
  assign axi.RREADY    = in_data_s && req.rsp_ready[grant_r];
  assign req.rsp_valid = (in_data_s && axi.RVALID) ? onehot(grant_r) : {NUM_REQ{1'b0}};
  assign req.rsp_data  = axi.RDATA;
  assign req.rsp_last  = in_data_s && axi.RLAST;
  assign req.rsp_resp  = in_data_s ? axi.RRESP : 2'b00;

`ifdef AXI_RD_ARB_CHECK_EN
  logic err_r;

  // RLAST must coincide exactly with the beat whose count equals ARLEN, and RID must match ARID
  function automatic logic beat_bad(input logic [NUM_ID-1:0] rid, input logic [NUM_ID-1:0] arid,
                                    input logic last, input logic [8:0] cnt, input logic [7:0] len);
    beat_bad = (rid != arid) || (last != (cnt == {1'b0, len}));
  endfunction

  // Sticky protocol error flag
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_r <= 1'b0;
    end else if (rd_beat_s && beat_bad(axi.RID, axi.ARID, axi.RLAST, beat_r, arlen_r)) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  logic unused_s;
  assign unused_s = ^{axi.RID, beat_r};
  assign err      = 1'b0;
`endif

endmodule
